// File: rtl/mem_bus_pkg.sv
// Shared encodings for the processor memory bus arbiter.
package mem_bus_pkg;

  // AMBA-style transfer type encodings; 2'b01 is never driven
  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_NSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;

  // Bit positions within m_prot
  localparam int unsigned PROT_DATA = 0;
  localparam int unsigned PROT_PRIV = 1;

  // Owner of an address phase; OWN_IDLE also means "no response owner"
  typedef enum logic [1:0] {
    OWN_IDLE  = 2'b00,
    OWN_FETCH = 2'b01,
    OWN_DATA  = 2'b10
  } owner_e;

endpackage

// File: rtl/arb_run_counter.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module arb_run_counter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_f_req,
  input  logic i_grant_data,
  input  logic i_grant_fetch,
  output logic o_force_fetch
);

  localparam logic [3:0] MaxRun = 4'(MAX_DATA_RUN);

  logic [3:0] r_count;
  logic [3:0] w_count_d;

  // Clear when fetch is served or no longer waiting; count data grants up to the limit
  always_comb begin
    w_count_d = r_count;
    if (!i_f_req || i_grant_fetch) begin
      w_count_d = 4'd0;
    end else if (i_grant_data && (r_count != MaxRun)) begin
      w_count_d = r_count + 4'd1;
    end
  end

  // Counter state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= 4'd0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign o_force_fetch = (r_count == MaxRun);

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
module memory_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              priv,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] d_wdata,
  input  logic              d_write,
  input  logic              d_size,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [ADDR_W-1:0] resp_rdata,
  output logic              resp_abort,
  output logic [ADDR_W-1:0] m_addr,
  output logic [ADDR_W-1:0] m_wdata,
  output logic              m_write,
  output logic              m_size,
  output logic [1:0]        m_prot,
  output logic [1:0]        m_trans,
  input  logic [ADDR_W-1:0] m_rdata,
  input  logic              m_abort
);

  owner_e            r_owner, w_owner_d, r_resp_owner;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [ADDR_W-1:0] r_wdata, w_wdata_d;
  logic              r_write, w_write_d;
  logic              r_size, w_size_d;
  logic [1:0]        r_prot, w_prot_d;
  logic [1:0]        r_trans, w_trans_d;
  logic              w_force_fetch;
  logic              w_seq;

  arb_run_counter #(
    .MAX_DATA_RUN (MAX_DATA_RUN)
  ) u_run_counter (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_f_req       (f_req),
    .i_grant_data  (w_owner_d == OWN_DATA),
    .i_grant_fetch (w_owner_d == OWN_FETCH),
    .o_force_fetch (w_force_fetch)
  );

  // Grant: data wins unless fetch has waited out its run limit
  always_comb begin
    w_owner_d = OWN_IDLE;
    if (d_req && f_req) begin
      w_owner_d = w_force_fetch ? OWN_FETCH : OWN_DATA;
    end else if (d_req) begin
      w_owner_d = OWN_DATA;
    end else if (f_req) begin
      w_owner_d = OWN_FETCH;
    end
  end

  // Address-phase fields for the granted owner; idle cycles hold the last fields
  always_comb begin
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_write_d = r_write;
    w_size_d  = r_size;
    w_prot_d  = r_prot;
    unique case (w_owner_d)
      OWN_FETCH: begin
        w_addr_d            = f_addr;
        w_wdata_d           = '0;
        w_write_d           = 1'b0;
        w_size_d            = 1'b1;
        w_prot_d[PROT_DATA] = 1'b0;
        w_prot_d[PROT_PRIV] = priv;
      end
      OWN_DATA: begin
        w_addr_d            = d_addr;
        w_wdata_d           = d_wdata;
        w_write_d           = d_write;
        w_size_d            = d_size;
        w_prot_d[PROT_DATA] = 1'b1;
        w_prot_d[PROT_PRIV] = priv;
      end
      default: ;
    endcase
    // SEQ needs an unbroken run by one owner, same direction, next word (wraps mod 2^ADDR_W)
    w_seq = (w_owner_d == r_owner) && (r_owner != OWN_IDLE) &&
            (w_addr_d == r_addr + ADDR_W'(4)) && (w_write_d == r_write);
    if (w_owner_d == OWN_IDLE) begin
      w_trans_d = TRANS_IDLE;
    end else begin
      w_trans_d = w_seq ? TRANS_SEQ : TRANS_NSEQ;
    end
  end

  // Address-phase and response-owner registers; reset drops any in-flight response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner      <= OWN_IDLE;
      r_resp_owner <= OWN_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_size       <= 1'b0;
      r_prot       <= 2'b00;
      r_trans      <= TRANS_IDLE;
    end else begin
      r_owner      <= w_owner_d;
      r_resp_owner <= r_owner;
      r_addr       <= w_addr_d;
      r_wdata      <= w_wdata_d;
      r_write      <= w_write_d;
      r_size       <= w_size_d;
      r_prot       <= w_prot_d;
      r_trans      <= w_trans_d;
    end
  end

  assign m_addr     = r_addr;
  assign m_wdata    = r_wdata;
  assign m_write    = r_write;
  assign m_size     = r_size;
  assign m_prot     = r_prot;
  assign m_trans    = r_trans;
  assign f_ack      = (r_owner == OWN_FETCH);
  assign d_ack      = (r_owner == OWN_DATA);
  assign f_rvalid   = (r_resp_owner == OWN_FETCH);
  assign d_rvalid   = (r_resp_owner == OWN_DATA);
  assign resp_rdata = m_rdata;
  assign resp_abort = m_abort;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Self-checking bench for memory_bus_arbiter: vector table, grant-order run, reset corner.
module tb_memory_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        priv;
  logic        f_req, d_req, d_write, d_size;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic        f_ack, f_rvalid, d_ack, d_rvalid, resp_abort;
  logic [31:0] resp_rdata, m_addr, m_wdata;
  logic        m_write, m_size;
  logic [1:0]  m_prot, m_trans;
  logic [31:0] m_rdata = 32'h0;
  logic        m_abort = 1'b0;

  memory_bus_arbiter #(
    .MAX_DATA_RUN (4),
    .ADDR_W       (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .priv       (priv),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_ack      (f_ack),
    .f_rvalid   (f_rvalid),
    .d_req      (d_req),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_write    (d_write),
    .d_size     (d_size),
    .d_ack      (d_ack),
    .d_rvalid   (d_rvalid),
    .resp_rdata (resp_rdata),
    .resp_abort (resp_abort),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_write    (m_write),
    .m_size     (m_size),
    .m_prot     (m_prot),
    .m_trans    (m_trans),
    .m_rdata    (m_rdata),
    .m_abort    (m_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(negedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] golden(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: unwritten words read as golden(addr); 0xFFFFFFFC aborts
  logic [31:0] mem [logic [31:0]];
  always @(posedge clk) begin
    if (m_trans[1]) begin
      if (m_write) begin
        mem[m_addr] = m_wdata;
        m_rdata <= 32'h0;
      end else begin
        m_rdata <= mem.exists(m_addr) ? mem[m_addr] : golden(m_addr);
      end
      m_abort <= (m_addr == 32'hFFFF_FFFC);
    end else begin
      m_rdata <= 32'h0;
      m_abort <= 1'b0;
    end
  end

  // Scoreboard of expected responses, in issue order
  typedef struct {
    logic        is_data;
    logic        chk_data;
    logic [31:0] rdata;
    logic        abort;
    int          due;
  } exp_t;
  exp_t sb[$];

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      if (f_ack || d_ack) check("ack_exclusive", {31'b0, f_ack & d_ack}, 32'd0);
      if (f_rvalid || d_rvalid) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", {30'b0, f_rvalid, d_rvalid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rvalid_exclusive", {31'b0, f_rvalid & d_rvalid}, 32'd0);
          check("rvalid_owner", {31'b0, d_rvalid}, {31'b0, e.is_data});
          check("resp_cycle", 32'(cyc), 32'(e.due));
          if (e.chk_data) check("resp_rdata", resp_rdata, e.rdata);
          check("resp_abort", {31'b0, resp_abort}, {31'b0, e.abort});
        end
      end
      if (sb.size() != 0 && sb[0].due < cyc) begin
        check("missing_rvalid", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  typedef struct {
    logic        is_data;
    logic        write;
    logic        size;
    logic        priv;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_trans;
    logic [31:0] exp_rdata;
    logic        exp_abort;
  } vec_t;

  function automatic vec_t mk(input logic is_data, input logic write, input logic size,
                              input logic pv, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] tr, input logic [31:0] rd, input logic ab);
    vec_t v;
    v.is_data = is_data; v.write = write; v.size = size; v.priv = pv; v.addr = addr;
    v.wdata = wdata; v.exp_trans = tr; v.exp_rdata = rd; v.exp_abort = ab;
    return v;
  endfunction

  // Present one request, wait (bounded) for its ack, check the address phase, log expectation
  task automatic do_xfer(input vec_t v, input int idx);
    logic got;
    exp_t e;
    priv = v.priv;
    if (v.is_data) begin
      d_req = 1'b1; d_addr = v.addr; d_wdata = v.wdata; d_write = v.write; d_size = v.size;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = v.is_data ? d_ack : f_ack;
    end
    if (!got) begin
      $display("FAIL ack_timeout[%0d]: got no ack required ack within 10 cycles", idx);
      checks++; errors++;
    end else begin
      check($sformatf("m_trans[%0d]", idx), {30'b0, m_trans}, {30'b0, v.exp_trans});
      check($sformatf("m_addr[%0d]", idx), m_addr, v.addr);
      check($sformatf("m_write[%0d]", idx), {31'b0, m_write}, {31'b0, v.is_data & v.write});
      check($sformatf("m_size[%0d]", idx), {31'b0, m_size}, {31'b0, v.is_data ? v.size : 1'b1});
      check($sformatf("m_wdata[%0d]", idx), m_wdata, v.is_data ? v.wdata : 32'h0);
      check($sformatf("m_prot[%0d]", idx), {30'b0, m_prot}, {30'b0, v.priv, v.is_data});
      check($sformatf("other_ack[%0d]", idx), {31'b0, v.is_data ? f_ack : d_ack}, 32'd0);
      e.is_data = v.is_data; e.chk_data = !(v.is_data && v.write);
      e.rdata = v.exp_rdata; e.abort = v.exp_abort; e.due = cyc + 1;
      sb.push_back(e);
    end
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];
  logic exp_f[10];
  exp_t ge;

  initial begin
    reset = 1'b1; priv = 1'b0;
    f_req = 1'b0; f_addr = 32'h0;
    d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_write = 1'b0; d_size = 1'b0;

    // Reset values
    #12;
    check("rst_m_trans", {30'b0, m_trans}, 32'd0);
    check("rst_m_addr", m_addr, 32'h0);
    check("rst_m_wdata", m_wdata, 32'h0);
    check("rst_ctrl", {27'b0, m_write, m_size, m_prot, f_ack}, 32'd0);
    check("rst_acks", {29'b0, d_ack, f_rvalid, d_rvalid}, 32'd0);
    reset = 1'b0;
    idle(2);

    //          D  W  S  P  addr          wdata         trans  rdata                   abort
    vecs[0]  = mk(0, 0, 0, 0, 32'h0000_0100, 32'h0,        2'b10, golden(32'h100),        0);
    vecs[1]  = mk(0, 0, 0, 0, 32'h0000_0104, 32'h0,        2'b11, golden(32'h104),        0);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0000_0108, 32'h0,        2'b11, golden(32'h108),        0);
    vecs[3]  = mk(1, 1, 1, 0, 32'h0000_0200, 32'hDEADBEEF, 2'b10, 32'h0,                  0);
    vecs[4]  = mk(1, 0, 1, 0, 32'h0000_0200, 32'h0,        2'b10, 32'hDEADBEEF,           0);
    vecs[5]  = mk(0, 0, 0, 1, 32'h0000_0300, 32'h0,        2'b10, golden(32'h300),        0);
    vecs[6]  = mk(1, 0, 1, 1, 32'h0000_0304, 32'h0,        2'b10, golden(32'h304),        0);
    vecs[7]  = mk(0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,        2'b10, golden(32'hFFFF_FFFC),  1);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0000_0000, 32'h0,        2'b11, golden(32'h0),          0);
    vecs[9]  = mk(1, 0, 0, 0, 32'h0000_0000, 32'h0,        2'b10, golden(32'h0),          0);
    vecs[10] = mk(1, 0, 1, 0, 32'h0000_0004, 32'h0,        2'b11, golden(32'h4),          0);
    for (int i = 0; i < 11; i++) do_xfer(vecs[i], i);
    idle(4);
    check("sb_drained_table", 32'(sb.size()), 32'd0);

    // Both requesters held: fetch forced through after four data grants
    exp_f = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    priv = 1'b0;
    f_req = 1'b1; f_addr = 32'h0000_0400;
    d_req = 1'b1; d_addr = 32'h0000_0500; d_write = 1'b0; d_size = 1'b1; d_wdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("grant_f[%0d]", i), {31'b0, f_ack}, {31'b0, exp_f[i]});
      check($sformatf("grant_d[%0d]", i), {31'b0, d_ack}, {31'b0, !exp_f[i]});
      ge.is_data = !exp_f[i]; ge.chk_data = 1'b1; ge.abort = 1'b0; ge.due = cyc + 1;
      ge.rdata = exp_f[i] ? golden(32'h400) : golden(32'h500);
      sb.push_back(ge);
    end
    f_req = 1'b0; d_req = 1'b0;
    idle(4);
    check("sb_drained_grant", 32'(sb.size()), 32'd0);

    // Reset during the ack cycle: outputs clear at once, the response never appears
    f_req = 1'b1; f_addr = 32'h0000_0600;
    @(posedge clk); #1;
    check("rst_pre_ack", {31'b0, f_ack}, 32'd1);
    f_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_m_trans", {30'b0, m_trans}, 32'd0);
    check("async_m_addr", m_addr, 32'h0);
    check("async_ctrl", {28'b0, m_write, m_size, m_prot}, 32'd0);
    check("async_acks", {28'b0, f_ack, d_ack, f_rvalid, d_rvalid}, 32'd0);
    @(posedge clk); #1;
    check("rst_no_rvalid", {31'b0, f_rvalid}, 32'd0);
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_rvalid[%0d]", i), {30'b0, f_rvalid, d_rvalid}, 32'd0);
    end
    check("sb_drained_end", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
Shares the single processor memory interface between the instruction-fetch requester (f_) and the load/store data requester (d_). Issues one address phase per cycle on the memory side, using AMBA-style trans encoding, and routes the response back to the requester that issued it one cycle later. Data has priority; a fairness counter bounds fetch starvation.

Parameters:
MAX_DATA_RUN, 4, max consecutive data grants while f_req is pending before fetch is forced a grant (1..15)
ADDR_W, 32, address/data width

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-high reset
priv  in  1  current privileged mode; drives m_prot[1]
f_req  in  1  fetch request; held with f_addr until f_ack
f_addr  in  32  fetch word address
f_ack  out  1  fetch address phase issued this cycle
f_rvalid  out  1  fetch response on resp_rdata/resp_abort this cycle
d_req  in  1  data request; held with d_* until d_ack
d_addr  in  32  data address
d_wdata  in  32  store data
d_write  in  1  1=store, 0=load
d_size  in  1  1=word, 0=byte
d_ack  out  1  data address phase issued this cycle
d_rvalid  out  1  data response (load data or store completion) this cycle
resp_rdata  out  32  m_rdata passthrough, valid only with f_rvalid/d_rvalid
resp_abort  out  1  m_abort passthrough, valid only with f_rvalid/d_rvalid
m_addr  out  32  memory address (registered)
m_wdata  out  32  memory write data (registered; 0 on reads)
m_write  out  1  memory write strobe (registered)
m_size  out  1  memory transfer size (registered; 1 for fetch)
m_prot  out  2  [0]=1 data/0 opcode, [1]=priv (registered)
m_trans  out  2  00 IDLE, 10 NSEQ, 11 SEQ; 01 never driven
m_rdata  in  32  memory read data, valid the cycle after the address phase
m_abort  in  1  memory abort, same timing as m_rdata

Behaviour:
- Reset (async, any time): m_trans=00; m_addr, m_wdata, m_write, m_size, m_prot=0; f_ack, d_ack, f_rvalid, d_rvalid=0; owner=IDLE; resp_owner=NONE; run counter=0. An in-flight response is discarded: no rvalid is issued after reset deasserts.
- Address-phase FSM, state = owner of the current address phase: IDLE, FETCH, DATA. Next state is chosen each posedge from the requests sampled at that edge.
- Grant: d_req only -> DATA. f_req only -> FETCH. Both -> DATA, unless the run counter equals MAX_DATA_RUN, then FETCH. Neither -> IDLE.
- Run counter: increments on each DATA grant while f_req=1. Clears on a FETCH grant or whenever f_req=0. Saturates at MAX_DATA_RUN.
- On grant at edge k, the following are registered and held for cycle k..k+1: m_addr, m_wdata, m_write, m_size, m_prot, m_trans, and the matching x_ack=1. Fetch drives m_write=0, m_size=1, m_wdata=0, m_prot[0]=0. Data drives its own fields and m_prot[0]=1.
- x_ack is high for exactly one cycle per transfer. The requester may present the next request in the cycle after ack, giving back-to-back transfers at one per cycle.
- m_trans=11 (SEQ) only when all hold: same owner as the previous cycle's address phase, no IDLE gap, m_addr = previous m_addr + 4, and same m_write. Otherwise 10 (NSEQ). Address arithmetic wraps modulo 2^32, so 0xFFFFFFFC -> 0x00000000 is SEQ.
- resp_owner <= owner at each posedge. In the next cycle, x_rvalid = (resp_owner==x), driven combinationally. resp_rdata/resp_abort pass m_rdata/m_abort through unregistered. Latency: request sampled at edge k, response at cycle k+1..k+2.
- Stores also produce d_rvalid; resp_rdata is don't-care for stores, resp_abort is valid.
- An abort does not stall or flush the arbiter; the requester handles it.
- Owner switch between cycles needs no idle cycle.

Decomposition:
- Shared package mem_bus_pkg: trans encodings (TRANS_IDLE=2'b00, TRANS_NSEQ=2'b10, TRANS_SEQ=2'b11), prot bit indices (PROT_DATA=0, PROT_PRIV=1), owner enum {OWN_IDLE, OWN_FETCH, OWN_DATA}.
- One sub-module: arb_run_counter (saturating fairness counter, parameter MAX_DATA_RUN, outputs force_fetch).

Test Plan:
- f_req held with f_addr=0x100, 0x104, 0x108 on successive acks -> m_trans 10,11,11; f_rvalid one cycle after each ack; resp_rdata equals memory word at 0x100/0x104/0x108.
- d_req and f_req both held continuously, MAX_DATA_RUN=4 -> grant order D,D,D,D,F,D,D,D,D,F; exactly one x_ack per cycle.
- d_write=1, d_addr=0x200, d_wdata=0xDEADBEEF, then load 0x200 -> m_write=1, m_prot=2'b01 (priv=0); load returns 0xDEADBEEF with d_rvalid.
- Fetch at 0x300, then data at 0x304 back-to-back -> data phase is NSEQ (owner change); f_rvalid then d_rvalid in consecutive cycles.
- Assert reset in the cycle after a fetch ack -> f_rvalid stays 0; m_trans=00 immediately (async); all outputs at reset values.
- f_addr=0xFFFFFFFC then 0x00000000 -> second phase m_trans=11; m_abort=1 during the first response -> resp_abort=1 with f_rvalid.
